// File: rtl/mem_bckdr_arb.sv
// Two-requester burst arbiter driving a single-port backdoor memory interface.
// Define MEM_BCKDR_ARB_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_bckdr_arb #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   input  logic [1:0]      req_valid,
   input  logic [1:0]      req_write,
   input  logic [2*AW-1:0] req_addr,
   input  logic [7:0]      req_len,
   output logic [1:0]      req_ready,
   input  logic [2*DW-1:0] wdata,
   input  logic [1:0]      wvalid,
   output logic [1:0]      wready,
   output logic [DW-1:0]   rd_data,
   output logic            rd_valid,
   output logic            rd_id,
   output logic [AW-1:0]   bd_addr,
   output logic [DW-1:0]   bd_data_o,
   output logic            bd_read,
   output logic            bd_write,
   input  logic [DW-1:0]   bd_data_i,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, WR, RD, RD_TAIL, GAP} state_t;

   state_t          state_q, state_d;
   logic            g_q, g_d;
   logic            rr_q, rr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [3:0]      len_q, len_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   bd_addr_q, bd_addr_d;
   logic [DW-1:0]   bd_data_q, bd_data_d;
   logic            bd_read_q, bd_read_d;
   logic            bd_write_q, bd_write_d;
   logic            rd_valid_q, rd_valid_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic            rd_id_q, rd_id_d;
   logic [1:0]      wready_q, wready_d;
   logic            busy_q, busy_d;
   logic [1:0]      req_ready_c;
   logic            grant;

   // Winner among current requests; rr_q holds the last granted requester.
   always_comb begin
`ifdef MEM_BCKDR_ARB_PRIO_EN
      grant = ~req_valid[0];
`else
      grant = (&req_valid) ? ~rr_q : req_valid[1];
`endif
   end

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      rr_d        = rr_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      bd_addr_d   = bd_addr_q;
      bd_data_d   = bd_data_q;
      bd_read_d   = 1'b0;
      bd_write_d  = 1'b0;
      req_ready_c = 2'b00;
      // Read data returns one cycle after each bd_read cycle.
      rd_valid_d  = bd_read_q;
      rd_data_d   = bd_read_q ? bd_data_i : rd_data_q;
      rd_id_d     = bd_read_q ? g_q : rd_id_q;

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready_c = grant ? 2'b10 : 2'b01;
               g_d         = grant;
               rr_d        = grant;
               addr_d      = grant ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
               len_d       = grant ? req_len[7:4] : req_len[3:0];
               cnt_d       = 4'd0;
               state_d     = req_write[grant] ? WR : RD;
            end
         end
         WR: begin
            if (wvalid[g_q]) begin
               bd_write_d = 1'b1;
               bd_data_d  = g_q ? wdata[2*DW-1:DW] : wdata[DW-1:0];
               bd_addr_d  = addr_q;
               addr_d     = addr_q + AW'(1);
               if (cnt_q == len_q) state_d = GAP;
               else                cnt_d   = cnt_q + 4'd1;
            end
         end
         RD: begin
            bd_read_d = 1'b1;
            bd_addr_d = addr_q;
            addr_d    = addr_q + AW'(1);
            if (cnt_q == len_q) state_d = RD_TAIL;
            else                cnt_d   = cnt_q + 4'd1;
         end
         RD_TAIL: state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wready_d = (state_d == WR) ? (g_d ? 2'b10 : 2'b01) : 2'b00;
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q    <= IDLE;
         g_q        <= 1'b0;
         rr_q       <= 1'b1;
         addr_q     <= '0;
         len_q      <= 4'd0;
         cnt_q      <= 4'd0;
         bd_addr_q  <= '0;
         bd_data_q  <= '0;
         bd_read_q  <= 1'b0;
         bd_write_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_id_q    <= 1'b0;
         wready_q   <= 2'b00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         rr_q       <= rr_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         bd_addr_q  <= bd_addr_d;
         bd_data_q  <= bd_data_d;
         bd_read_q  <= bd_read_d;
         bd_write_q <= bd_write_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_id_q    <= rd_id_d;
         wready_q   <= wready_d;
         busy_q     <= busy_d;
      end
   end

   assign req_ready = req_ready_c;
   assign wready    = wready_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign rd_id     = rd_id_q;
   assign bd_addr   = bd_addr_q;
   assign bd_data_o = bd_data_q;
   assign bd_read   = bd_read_q;
   assign bd_write  = bd_write_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bckdr_arb.sv
// Scoreboard bench for mem_bckdr_arb: stimulus pushes expected grants, backdoor beats and read returns.
module tb_mem_bckdr_arb;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic            wb_clk = 1'b0;
   logic            wb_rst;
   logic [1:0]      req_valid, req_write, req_ready, wvalid, wready;
   logic [2*AW-1:0] req_addr;
   logic [7:0]      req_len;
   logic [2*DW-1:0] wdata;
   logic [DW-1:0]   rd_data, bd_data_o, bd_data_i;
   logic            rd_valid, rd_id, bd_read, bd_write, busy;
   logic [AW-1:0]   bd_addr;

   mem_bckdr_arb #(.AW(AW), .DW(DW)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
      .req_ready(req_ready), .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id),
      .bd_addr(bd_addr), .bd_data_o(bd_data_o), .bd_read(bd_read), .bd_write(bd_write),
      .bd_data_i(bd_data_i), .busy(busy)
   );

   always #5 wb_clk = ~wb_clk;

   // Backdoor memory returns its own address as data.
   assign bd_data_i = bd_addr;

   typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } bd_t;
   typedef struct { logic [31:0] data; logic id; } rd_t;

   bd_t  bd_q[$];
   rd_t  rd_q[$];
   logic gnt_q[$];
   int   tests = 0;
   int   fails = 0;
   int   gnt_cnt = 0;
   logic mon_en = 1'b0;
   logic prev_bd_read = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: DUT output with nothing expected at %0t", name, $time);
   endtask

   // Monitor: compare every DUT output event against the scoreboard queues.
   always @(negedge wb_clk) begin
      if (mon_en) begin
         chk("bd_rw_excl", 32'(bd_read & bd_write), 32'd0);
         chk("rd_latency", 32'(rd_valid), 32'(prev_bd_read));
         if (req_ready != 2'b00) begin
            gnt_cnt <= gnt_cnt + 1;
            if (gnt_q.size() == 0) unexpected("grant");
            else begin
               logic g;
               g = gnt_q.pop_front();
               chk("grant", 32'(req_ready), g ? 32'd2 : 32'd1);
            end
         end
         if (bd_write || bd_read) begin
            if (bd_q.size() == 0) unexpected("bd_beat");
            else begin
               bd_t e;
               e = bd_q.pop_front();
               chk("bd_write", 32'(bd_write), 32'(e.wr));
               chk("bd_addr", bd_addr, e.addr);
               if (e.wr) chk("bd_data_o", bd_data_o, e.data);
            end
         end
         if (rd_valid) begin
            if (rd_q.size() == 0) unexpected("rd_valid");
            else begin
               rd_t r;
               r = rd_q.pop_front();
               chk("rd_data", rd_data, r.data);
               chk("rd_id", 32'(rd_id), 32'(r.id));
            end
         end
      end
      prev_bd_read <= bd_read;
   end

   task automatic set_req(input int id, input logic wr, input logic [31:0] addr, input logic [3:0] len);
      req_valid[id]          = 1'b1;
      req_write[id]          = wr;
      req_addr[id*AW +: AW]  = addr;
      req_len[id*4 +: 4]     = len;
   endtask

   task automatic wait_ready(input int id);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge wb_clk);
         if (req_ready[id]) begin ok = 1'b1; break; end
      end
      chk("req_ready_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge wb_clk);
         if (!busy) break;
      end
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic exp_read(input int id, input logic [31:0] addr, input logic [3:0] len);
      for (int i = 0; i <= int'(len); i++) begin
         bd_q.push_back('{1'b0, addr + 32'(i), 32'd0});
         rd_q.push_back('{addr + 32'(i), 1'(id)});
      end
   endtask

   task automatic do_read(input int id, input logic [31:0] addr, input logic [3:0] len);
      gnt_q.push_back(1'(id));
      exp_read(id, addr, len);
      @(posedge wb_clk); #1;
      set_req(id, 1'b0, addr, len);
      wait_ready(id);
      @(posedge wb_clk); #1;
      req_valid[id] = 1'b0;
      wait_idle();
   endtask

   task automatic do_write(input int id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] dbase, input bit gaps);
      gnt_q.push_back(1'(id));
      for (int i = 0; i <= int'(len); i++) bd_q.push_back('{1'b1, addr + 32'(i), dbase + 32'(i)});
      @(posedge wb_clk); #1;
      set_req(id, 1'b1, addr, len);
      wait_ready(id);
      @(posedge wb_clk); #1;
      req_valid[id] = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wvalid[id]            = 1'b1;
         wdata[id*DW +: DW]    = dbase + 32'(b);
         @(negedge wb_clk);
         chk("wready", 32'(wready), (id == 1) ? 32'd2 : 32'd1);
         @(posedge wb_clk); #1;
         wvalid[id] = 1'b0;
         if (gaps && b < int'(len)) begin @(posedge wb_clk); #1; end
      end
      wait_idle();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wb_rst    = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
      wdata     = '0; wvalid = '0;
      repeat (3) @(posedge wb_clk);
      #1 wb_rst = 1'b0;
      @(negedge wb_clk);
      chk("rst_bd_read", 32'(bd_read), 32'd0);
      chk("rst_bd_write", 32'(bd_write), 32'd0);
      chk("rst_bd_addr", bd_addr, 32'd0);
      chk("rst_bd_data_o", bd_data_o, 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_rd_id", 32'(rd_id), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      mon_en = 1'b1;

      // Both requesters asserting continuously from reset.
      begin
         logic ids [4];
`ifdef MEM_BCKDR_ARB_PRIO_EN
         ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
         ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
         foreach (ids[k]) begin
            gnt_q.push_back(ids[k]);
            exp_read(int'(ids[k]), ids[k] ? 32'h400 : 32'h300, 4'd0);
         end
         @(posedge wb_clk); #1;
         set_req(0, 1'b0, 32'h300, 4'd0);
         set_req(1, 1'b0, 32'h400, 4'd0);
         for (int i = 0; i < 100; i++) begin
            @(posedge wb_clk);
            if (gnt_cnt >= 4) break;
         end
         #1 req_valid = 2'b00;
         chk("grant_count", 32'(gnt_cnt), 32'd4);
         wait_idle();
      end

      do_write(0, 32'h100, 4'd9, 32'hA0, 1'b0);
      do_read(1, 32'h200, 4'd3);
      do_write(1, 32'h600, 4'd3, 32'hB0, 1'b1);
      do_read(0, 32'hFFFF_FFFE, 4'd3);

      // Reset lands on the third beat of a 16-beat write.
      gnt_q.push_back(1'b0);
      bd_q.push_back('{1'b1, 32'h500, 32'hC0});
      bd_q.push_back('{1'b1, 32'h501, 32'hC1});
      @(posedge wb_clk); #1;
      set_req(0, 1'b1, 32'h500, 4'd15);
      wait_ready(0);
      @(posedge wb_clk); #1;
      req_valid[0] = 1'b0;
      for (int b = 0; b < 3; b++) begin
         wvalid[0]    = 1'b1;
         wdata[DW-1:0] = 32'hC0 + 32'(b);
         if (b == 2) wb_rst = 1'b1;
         @(posedge wb_clk); #1;
      end
      wb_rst    = 1'b0;
      wvalid[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge wb_clk);
         chk("post_rst_busy", 32'(busy), 32'd0);
         chk("post_rst_bd_write", 32'(bd_write), 32'd0);
         chk("post_rst_wready", 32'(wready), 32'd0);
      end
      gnt_q.push_back(1'b0);
      exp_read(0, 32'h700, 4'd0);
      @(posedge wb_clk); #1;
      set_req(0, 1'b0, 32'h700, 4'd0);
      set_req(1, 1'b0, 32'h800, 4'd0);
      wait_ready(0);
      @(posedge wb_clk); #1;
      req_valid = 2'b00;
      wait_idle();

      repeat (3) @(negedge wb_clk);
      chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
      chk("bd_q_empty", 32'(bd_q.size()), 32'd0);
      chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_bckdr_arb.md
MEM_BCKDR_ARB -- requirements
Module: mem_bckdr_arb

Interface
REQ-001 SHALL have parameter AW, default 32, backdoor address width.
REQ-002 SHALL have parameter DW, default 32, backdoor data width.
REQ-003 SHALL have port wb_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester burst request, index = requester id.
REQ-006 SHALL have port req_write  input  2  1 = write burst, 0 = read burst.
REQ-007 SHALL have port req_addr  input  2*AW  burst start address; requester i in bits [i*AW +: AW].
REQ-008 SHALL have port req_len  input  8  beats minus one; requester i in bits [i*4 +: 4]; 1..16 beats.
REQ-009 SHALL have port req_ready  output  2  one-cycle request-accept pulse.
REQ-010 SHALL have port wdata  input  2*DW  write beat data per requester.
REQ-011 SHALL have port wvalid  input  2  write beat valid per requester.
REQ-012 SHALL have port wready  output  2  write beat accept per requester.
REQ-013 SHALL have port rd_data  output  DW  returned read data.
REQ-014 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-015 SHALL have port rd_id  output  1  requester owning rd_data.
REQ-016 SHALL have ports bd_addr  output  AW, bd_data_o  output  DW, bd_read  output  1, bd_write  output  1  registered backdoor memory drive.
REQ-017 SHALL have port bd_data_i  input  DW  backdoor memory read data.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, WR, RD, RD_TAIL, GAP.
REQ-020 In IDLE with any req_valid, SHALL pulse req_ready for the granted requester g in that cycle, latch its addr/len/write, and enter WR or RD next cycle.
REQ-021 Arbitration SHALL be round-robin: with both requests valid, grant the requester not granted last; pointer updates only on grant.
REQ-022 WR: wready[g] SHALL be 1 and wready[!g] SHALL be 0; each wvalid[g]&wready[g] cycle SHALL produce, next cycle, bd_write=1, bd_data_o=beat data, bd_addr=start+beat index.
REQ-023 WR cycles without wvalid[g] SHALL drive bd_write=0 next cycle and hold the beat counter; there is no timeout.
REQ-024 After the (len+1)th write beat, SHALL enter GAP, one idle cycle, then IDLE.
REQ-025 RD: SHALL drive bd_read=1 for len+1 consecutive cycles, bd_addr=start, start+1, ...; then enter RD_TAIL for one cycle, then GAP.
REQ-026 bd_data_i SHALL be sampled at the edge ending each bd_read=1 cycle; rd_valid=1, rd_data=sample, rd_id=g in the following cycle (latency 1).
REQ-027 Address increment SHALL wrap modulo 2^AW.
REQ-028 req_valid falling after acceptance SHALL not affect the accepted burst; requests arriving outside IDLE SHALL wait.
REQ-029 bd_read and bd_write SHALL never be 1 simultaneously.

Reset
REQ-030 While wb_rst=1 at an edge, next cycle: state IDLE, bd_read=bd_write=0, bd_addr=0, bd_data_o=0, rd_valid=0, rd_data=0, rd_id=0, req_ready=wready=0, busy=0, round-robin pointer = 1 (requester 0 wins first).
REQ-031 Reset mid-burst SHALL abort it: no further bd_* beat or rd_valid after the reset edge.

Configuration
REQ-032 With macro MEM_BCKDR_ARB_PRIO_EN defined, arbitration SHALL be fixed priority, requester 0 always winning ties; undefined, REQ-021 round-robin applies.

Verification
REQ-033 Req0 write, addr 0x100, len 9, wvalid continuous, data 0xA0..0xA9 -> ten bd_write cycles, bd_addr 0x100..0x109, matching data, then busy low after GAP.
REQ-034 Req1 read, addr 0x200, len 3, bd_data_i = addr -> bd_read 4 cycles; rd_valid 4 cycles, rd_data 0x200..0x203, rd_id=1, each 1 cycle after its bd_read.
REQ-035 Both req_valid high continuously after reset -> grants 0,1,0,1; with MEM_BCKDR_ARB_PRIO_EN -> 0,0,0,0.
REQ-036 Write len 3, wvalid low every other cycle -> bd_write toggles, 4 beats total, addresses contiguous.
REQ-037 Read addr 0xFFFFFFFE, len 3 -> bd_addr FFFFFFFE, FFFFFFFF, 0, 1.
REQ-038 wb_rst asserted on the third beat of a 16-beat write -> bd_write 0 next cycle onward, busy 0, new request granted to requester 0.
